// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - fetch stage bus bundle
// Groups the instruction-memory request/grant/response channel, the branch
// redirect input and the decoder valid/ready channel.
//   master : instruction_fetch side
//   slave  : memory / decoder / branch-resolution side
interface instruction_fetch_if #(
  parameter int ADDR_W = 32
) ();
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [15:0]       imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_valid;
  logic [15:0]       instruction;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instruction, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instruction, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - Thumb halfword fetch stage with prefetch buffer
// Holds the PC, issues halfword fetches, queues returned instructions in an
// in-order {instruction, pc} buffer and hands them to the decoder.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : instruction_fetch_if.master (imem req/gnt/rvalid, redirect,
//           decoder instr_valid/instr_ready)
// Build option: FETCH_SKID_BUF_EN selects a 2-entry buffer (1 entry otherwise).
module instruction_fetch #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                 clk,
  input logic                 reset,
  instruction_fetch_if.master bus
);

`ifdef FETCH_SKID_BUF_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif
  localparam int CW = 2;
  localparam logic [ADDR_W-1:0] START_PC = RESET_PC & ~ADDR_W'(1);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] rsp_pc;     // pc of the oldest live outstanding request
  logic [CW-1:0]     occ;
  logic [CW-1:0]     outst;
  logic [CW-1:0]     stale;
  logic              valid_q;
  logic [15:0]       fifo_data [D];
  logic [ADDR_W-1:0] fifo_pc   [D];

  logic              req;
  logic              acc;
  logic              rsp;
  logic              push;
  logic              pop;
  logic [CW-1:0]     occ_n;
  logic [CW-1:0]     stale_n;
  logic [ADDR_W-1:0] target;
  logic [15:0]       nxt_data [D];
  logic [ADDR_W-1:0] nxt_pc   [D];
  int                wr_idx;

  // Credit check: never have more requests in flight plus buffered entries
  // than the buffer can hold. Forced low while reset is held.
  assign req    = reset && (state == RUN) && (({1'b0, occ} + {1'b0, outst}) < 3'(D));
  assign acc    = req && bus.imem_gnt;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp    = bus.imem_rvalid && (outst != '0);
  assign push   = rsp && (state == RUN);
  assign pop    = valid_q && bus.instr_ready;
  assign occ_n  = occ + CW'(push) - CW'(pop);
  assign target = bus.redirect_pc & ~ADDR_W'(1);
  // Everything still in flight after this cycle belongs to the old path.
  assign stale_n = outst + CW'(acc) - CW'(rsp);

  // Shift-register FIFO: entry 0 is always the head, so the decoder outputs
  // come straight from flops.
  always_comb begin
    nxt_data = fifo_data;
    nxt_pc   = fifo_pc;
    wr_idx   = int'(occ) - (pop ? 1 : 0);
    if (pop) begin
      for (int i = 0; i < D - 1; i++) begin
        nxt_data[i] = fifo_data[i+1];
        nxt_pc[i]   = fifo_pc[i+1];
      end
    end
    if (push) begin
      for (int i = 0; i < D; i++) begin
        if (i == wr_idx) begin
          nxt_data[i] = bus.imem_rdata;
          nxt_pc[i]   = rsp_pc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      fetch_pc <= START_PC;
      rsp_pc   <= START_PC;
      occ      <= '0;
      outst    <= '0;
      stale    <= '0;
      valid_q  <= 1'b0;
      for (int i = 0; i < D; i++) begin
        fifo_data[i] <= '0;
        fifo_pc[i]   <= START_PC;
      end
    end else if (bus.redirect_valid) begin
      // Redirect wins over everything; any response this cycle is dropped.
      state    <= (stale_n != '0) ? DRAIN : RUN;
      stale    <= stale_n;
      outst    <= stale_n;
      occ      <= '0;
      valid_q  <= 1'b0;
      fetch_pc <= target;
      rsp_pc   <= target;
    end else begin
      occ       <= occ_n;
      valid_q   <= (occ_n != '0);
      fifo_data <= nxt_data;
      fifo_pc   <= nxt_pc;
      outst     <= outst + CW'(acc) - CW'(rsp);
      if (acc) begin
        fetch_pc <= fetch_pc + ADDR_W'(2);
      end
      if (push) begin
        rsp_pc <= rsp_pc + ADDR_W'(2);
      end
      if (state == DRAIN && rsp) begin
        stale <= stale - CW'(1);
        if (stale == CW'(1)) begin
          state <= RUN;
        end
      end
    end
  end

  assign bus.imem_req    = req;
  assign bus.imem_addr   = fetch_pc;
  assign bus.instr_valid = valid_q;
  assign bus.instruction = fifo_data[0];
  assign bus.instr_pc    = fifo_pc[0];

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - randomized self-checking bench for instruction_fetch
module tb_instruction_fetch;
  localparam int          ADDR_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_SKID_BUF_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  instruction_fetch_if #(.ADDR_W(ADDR_W)) bus ();

  instruction_fetch #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          ndeliv = 0;
  logic [31:0] exp_pc;
  logic [31:0] req_pc;
  bit          mon_on = 1'b0;
  int          gnt_mode = 0;
  int          rsp_mode = 0;
  int          rdy_mode = 1;
  bit          redir = 1'b0;
  logic [31:0] redir_pc = '0;
  logic [31:0] pend[$];

  function automatic logic [15:0] memf(input logic [31:0] a);
    return a[16:1] ^ a[31:16] ^ 16'hA5C3;
  endfunction

  // One clock of memory/decoder/branch stimulus, entered and left at negedge.
  task automatic step();
    bit          g;
    bit          rv;
    bit          acc;
    logic [31:0] a;
    g  = (gnt_mode == 1) || (gnt_mode == 2 && $urandom_range(0, 1) == 1);
    rv = (pend.size() > 0) && (rsp_mode == 1 || (rsp_mode == 2 && $urandom_range(0, 2) != 0));
    bus.imem_gnt    = g;
    bus.imem_rvalid = rv;
    if (rv) bus.imem_rdata = memf(pend[0]);
    else    bus.imem_rdata = 16'($urandom);
    bus.redirect_valid = redir;
    bus.redirect_pc    = redir_pc;
    bus.instr_ready    = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 3) != 0);
    #1;
    acc = bus.imem_req && g;
    a   = bus.imem_addr;
    @(posedge clk);
    if (rv) void'(pend.pop_front());
    if (acc) pend.push_back(a);
    @(negedge clk);
    redir = 1'b0;
  endtask

  task automatic run_until(input int target, input int budget);
    for (int i = 0; i < budget && ndeliv < target; i++) step();
  endtask

  // Reference model: fetch addresses and delivered pcs are consecutive
  // halfwords from the last redirect target; delivered data is memf(pc).
  always @(negedge clk) begin
    #2;
    if (mon_on) begin
      n_cmp++;
      if (bus.imem_addr[0] !== 1'b0) begin
        n_err++;
        $display("FAIL imem_addr_bit0: got %h want even", bus.imem_addr);
      end
      if (bus.imem_req && bus.imem_gnt) begin
        n_cmp++;
        if (bus.imem_addr !== req_pc) begin
          n_err++;
          $display("FAIL grant_addr: got %h want %h", bus.imem_addr, req_pc);
        end
        req_pc = req_pc + 32'd2;
      end
      if (bus.instr_valid && bus.instr_ready) begin
        n_cmp += 2;
        if (bus.instr_pc !== exp_pc) begin
          n_err++;
          $display("FAIL deliver_pc: got %h want %h", bus.instr_pc, exp_pc);
        end
        if (bus.instruction !== memf(exp_pc)) begin
          n_err++;
          $display("FAIL deliver_instr: got %h want %h", bus.instruction, memf(exp_pc));
        end
        exp_pc = exp_pc + 32'd2;
        ndeliv++;
      end
      if (bus.redirect_valid) begin
        exp_pc = bus.redirect_pc & ~32'd1;
        req_pc = bus.redirect_pc & ~32'd1;
      end
    end
  end

  task automatic go_idle();
    gnt_mode = 0; rsp_mode = 1; rdy_mode = 1;
    repeat (6) step();
  endtask

  task automatic test_reset();
    bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = '0;
    bus.redirect_valid = 0; bus.redirect_pc = '0; bus.instr_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp += 5;
    if (bus.imem_req !== 1'b0)        begin n_err++; $display("FAIL rst_req: got %b want 0", bus.imem_req); end
    if (bus.imem_addr !== RESET_PC)   begin n_err++; $display("FAIL rst_addr: got %h want %h", bus.imem_addr, RESET_PC); end
    if (bus.instr_valid !== 1'b0)     begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.instr_valid); end
    if (bus.instruction !== 16'h0000) begin n_err++; $display("FAIL rst_instr: got %h want 0000", bus.instruction); end
    if (bus.instr_pc !== RESET_PC)    begin n_err++; $display("FAIL rst_pc: got %h want %h", bus.instr_pc, RESET_PC); end
    reset = 1'b1;
    exp_pc = RESET_PC; req_pc = RESET_PC; mon_on = 1'b1;
    #1;
    n_cmp += 2;
    if (bus.imem_req !== 1'b1)      begin n_err++; $display("FAIL first_req: got %b want 1", bus.imem_req); end
    if (bus.imem_addr !== RESET_PC) begin n_err++; $display("FAIL first_addr: got %h want %h", bus.imem_addr, RESET_PC); end
  endtask

  task automatic test_stream();
    int start;
    gnt_mode = 1; rsp_mode = 1; rdy_mode = 1;
    for (int c = 0; c < 2; c++) begin
      n_cmp++;
      if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL early_valid c%0d: got %b want 0", c, bus.instr_valid); end
      step();
    end
    n_cmp++;
    if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL first_valid: got %b want 1", bus.instr_valid); end
    start = ndeliv;
    run_until(start + 20, 100);
    n_cmp++;
    if (ndeliv < start + 20) begin n_err++; $display("FAIL stream_timeout: got %0d want %0d", ndeliv - start, 20); end
  endtask

  task automatic test_stall();
    int start;
    rdy_mode = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (bus.instr_valid) begin
        n_cmp += 2;
        if (bus.instr_pc !== exp_pc)          begin n_err++; $display("FAIL stall_pc: got %h want %h", bus.instr_pc, exp_pc); end
        if (bus.instruction !== memf(exp_pc)) begin n_err++; $display("FAIL stall_instr: got %h want %h", bus.instruction, memf(exp_pc)); end
      end
    end
    n_cmp += 2;
    if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid: got %b want 1", bus.instr_valid); end
    if (bus.imem_req !== 1'b0)    begin n_err++; $display("FAIL stall_req: got %b want 0", bus.imem_req); end
    rdy_mode = 1;
    start = ndeliv;
    run_until(start + 10, 60);
    n_cmp++;
    if (ndeliv < start + 10) begin n_err++; $display("FAIL stall_release_timeout: got %0d want 10", ndeliv - start); end
  endtask

  task automatic test_redirect_outstanding();
    int start;
    go_idle();
    gnt_mode = 1; rsp_mode = 0;
    for (int i = 0; i < 8 && bus.imem_req; i++) step();
    n_cmp++;
    if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL fill_req: got %b want 0", bus.imem_req); end
    redir = 1'b1; redir_pc = 32'h0000_0101;
    step();
    n_cmp += 3;
    if (bus.imem_addr !== 32'h100) begin n_err++; $display("FAIL redir_addr: got %h want 00000100", bus.imem_addr); end
    if (bus.imem_req !== 1'b0)     begin n_err++; $display("FAIL drain_req: got %b want 0", bus.imem_req); end
    if (bus.instr_valid !== 1'b0)  begin n_err++; $display("FAIL redir_clear: got %b want 0", bus.instr_valid); end
    rsp_mode = 1;
    for (int i = 0; i < D; i++) begin
      step();
      n_cmp++;
      if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL stale_valid %0d: got %b want 0", i, bus.instr_valid); end
    end
    n_cmp += 2;
    if (bus.imem_req !== 1'b1)     begin n_err++; $display("FAIL post_drain_req: got %b want 1", bus.imem_req); end
    if (bus.imem_addr !== 32'h100) begin n_err++; $display("FAIL post_drain_addr: got %h want 00000100", bus.imem_addr); end
    start = ndeliv;
    run_until(start + 4, 40);
    n_cmp++;
    if (ndeliv < start + 4) begin n_err++; $display("FAIL redir_timeout: got %0d want 4", ndeliv - start); end
  endtask

  task automatic test_redirect_collision();
    int start;
    go_idle();
    gnt_mode = 1; rsp_mode = 0;
    step();
    rsp_mode = 1; redir = 1'b1; redir_pc = 32'h0000_2000;
    step();
    n_cmp++;
    if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL coll_valid: got %b want 0", bus.instr_valid); end
    if (D == 2) begin
      n_cmp++;
      if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL coll_drain_req: got %b want 0", bus.imem_req); end
      step();
      n_cmp++;
      if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL coll_stale_valid: got %b want 0", bus.instr_valid); end
    end
    n_cmp += 2;
    if (bus.imem_req !== 1'b1)         begin n_err++; $display("FAIL coll_req: got %b want 1", bus.imem_req); end
    if (bus.imem_addr !== 32'h2000)    begin n_err++; $display("FAIL coll_addr: got %h want 00002000", bus.imem_addr); end
    start = ndeliv;
    run_until(start + 4, 40);
    n_cmp++;
    if (ndeliv < start + 4) begin n_err++; $display("FAIL coll_timeout: got %0d want 4", ndeliv - start); end
  endtask

  task automatic test_wrap();
    int start;
    go_idle();
    redir = 1'b1; redir_pc = 32'hFFFF_FFFE;
    step();
    gnt_mode = 1;
    n_cmp += 3;
    if (bus.imem_req !== 1'b1)         begin n_err++; $display("FAIL wrap_req: got %b want 1", bus.imem_req); end
    if (bus.imem_addr !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL wrap_addr0: got %h want fffffffe", bus.imem_addr); end
    if (bus.instr_valid !== 1'b0)      begin n_err++; $display("FAIL wrap_valid_r1: got %b want 0", bus.instr_valid); end
    step();
    n_cmp += 2;
    if (bus.imem_addr !== 32'h0)       begin n_err++; $display("FAIL wrap_addr1: got %h want 00000000", bus.imem_addr); end
    if (bus.instr_valid !== 1'b0)      begin n_err++; $display("FAIL wrap_valid_r2: got %b want 0", bus.instr_valid); end
    step();
    n_cmp++;
    if (bus.instr_valid !== 1'b1)      begin n_err++; $display("FAIL wrap_valid_r3: got %b want 1", bus.instr_valid); end
    start = ndeliv;
    run_until(start + 3, 30);
    n_cmp++;
    if (ndeliv < start + 3) begin n_err++; $display("FAIL wrap_timeout: got %0d want 3", ndeliv - start); end
  endtask

  task automatic test_reset_drain();
    int start;
    go_idle();
    gnt_mode = 1; rsp_mode = 0;
    step();
    gnt_mode = 0; redir = 1'b1; redir_pc = 32'h0000_0300;
    step();
    n_cmp++;
    if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL rd_drain_req: got %b want 0", bus.imem_req); end
    mon_on = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_cmp += 5;
    if (bus.imem_req !== 1'b0)        begin n_err++; $display("FAIL rd_req: got %b want 0", bus.imem_req); end
    if (bus.imem_addr !== RESET_PC)   begin n_err++; $display("FAIL rd_addr: got %h want %h", bus.imem_addr, RESET_PC); end
    if (bus.instr_valid !== 1'b0)     begin n_err++; $display("FAIL rd_valid: got %b want 0", bus.instr_valid); end
    if (bus.instruction !== 16'h0000) begin n_err++; $display("FAIL rd_instr: got %h want 0000", bus.instruction); end
    if (bus.instr_pc !== RESET_PC)    begin n_err++; $display("FAIL rd_pc: got %h want %h", bus.instr_pc, RESET_PC); end
    pend.delete();
    bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.redirect_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_pc = RESET_PC; req_pc = RESET_PC; mon_on = 1'b1;
    gnt_mode = 1; rsp_mode = 1;
    #1;
    n_cmp += 2;
    if (bus.imem_req !== 1'b1)      begin n_err++; $display("FAIL rd_restart_req: got %b want 1", bus.imem_req); end
    if (bus.imem_addr !== RESET_PC) begin n_err++; $display("FAIL rd_restart_addr: got %h want %h", bus.imem_addr, RESET_PC); end
    start = ndeliv;
    run_until(start + 4, 40);
    n_cmp++;
    if (ndeliv < start + 4) begin n_err++; $display("FAIL rd_timeout: got %0d want 4", ndeliv - start); end
  endtask

  task automatic test_random();
    int start;
    start = ndeliv;
    gnt_mode = 2; rsp_mode = 2; rdy_mode = 2;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 19) == 0) begin
        redir = 1'b1;
        redir_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7))) : $urandom;
      end
      step();
    end
    n_cmp++;
    if (ndeliv < start + 50) begin n_err++; $display("FAIL random_progress: got %0d want >=50", ndeliv - start); end
    gnt_mode = 1; rsp_mode = 1; rdy_mode = 1;
    start = ndeliv;
    run_until(start + 5, 50);
    n_cmp++;
    if (ndeliv < start + 5) begin n_err++; $display("FAIL random_settle: got %0d want 5", ndeliv - start); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_outstanding();
    test_redirect_collision();
    test_wrap();
    test_reset_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
